// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - frame field positions and parameter checks for spi_reg_rx
package spi_reg_pkg;

    // Data always occupies the bottom of the frame.
    localparam int DATA_LSB = 0;

    // Frame bit index of the address MSB (first bit on the wire).
    function automatic int addr_msb(input int frame_w);
        return frame_w - 1;
    endfunction

    // Frame bit index of the write-enable bit, just below the address.
    function automatic int we_bit(input int frame_w, input int addr_w);
        return frame_w - 1 - addr_w;
    endfunction

    // Serial position (0 = first bit) of the data MSB.
    function automatic int data_first_pos(input int frame_w, input int data_w);
        return frame_w - data_w;
    endfunction

    // Width of a counter that can hold positions 0 .. frame_w-1.
    function automatic int bitcnt_w(input int frame_w);
        return (frame_w > 2) ? $clog2(frame_w) : 1;
    endfunction

    // Legal parameter combinations; the readback address must be complete
    // before the first data position is driven on MISO.
    function automatic bit params_ok(input int frame_w, input int addr_w,
                                     input int data_w, input int channels);
        return (addr_w >= 1) && (data_w >= 1) && (channels >= 1)
            && (frame_w >= addr_w + 1 + data_w)
            && (frame_w - data_w > addr_w)
            && (channels <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/spi_reg_rx_if.sv
// rtl/spi_reg_rx_if.sv - SPI pin bundle between master and spi_reg_rx
interface spi_reg_rx_if;
    logic cs_n;
    logic sdo;
    logic sdi;

    modport master (output cs_n, output sdo, input sdi);
    modport slave  (input cs_n, input sdo, output sdi);
endinterface

// File: rtl/spi_bitcnt.sv
// rtl/spi_bitcnt.sv - frame bit counter with cs_n clear, terminal count and partial flag
module spi_bitcnt #(
    parameter int FRAME_W = 32,
    parameter int CW      = 5
) (
    input  logic          sclk,
    input  logic          reset,
    input  logic          cs_n,
    output logic [CW-1:0] bitcnt,
    output logic          tc,
    output logic          partial
);

    localparam logic [CW-1:0] LAST = CW'(FRAME_W - 1);

    logic [CW-1:0] cnt_nxt;

    // Wrap on the last bit so back-to-back frames need no idle cycle.
    always_comb begin
        tc      = (bitcnt == LAST);
        cnt_nxt = tc ? '0 : bitcnt + CW'(1);
    end

    // Bit position; cs_n high or reset holds it at zero asynchronously.
    always_ff @(posedge sclk or posedge reset or posedge cs_n) begin
        if (reset || cs_n) begin
            bitcnt <= '0;
        end else begin
            bitcnt <= cnt_nxt;
        end
    end

    // Remembers a frame in progress across cs_n so a truncation is visible
    // on the first edge of the next frame; only reset forgets it.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            partial <= 1'b0;
        end else if (!cs_n) begin
            partial <= (cnt_nxt != '0);
        end
    end

endmodule

// File: rtl/spi_reg_rx.sv
// rtl/spi_reg_rx.sv - SPI mode-0 slave writing and reading back per-channel holding registers
module spi_reg_rx
    import spi_reg_pkg::*;
#(
    parameter int FRAME_W  = 32,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 10,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                       sclk,
    input  logic                       reset,
    spi_reg_rx_if.slave                spi,
    output logic [CHANNELS*DATA_W-1:0] ch_data,
    output logic [CHANNELS-1:0]        ch_toggle,
    output logic [CNT_W-1:0]           frame_cnt,
    output logic                       addr_err,
    output logic                       short_err
);

    localparam int CW     = bitcnt_w(FRAME_W);
    localparam int AW1    = ADDR_W + 1;
    localparam int A_MSB  = addr_msb(FRAME_W);
    localparam int WE_POS = we_bit(FRAME_W, ADDR_W);

    localparam logic [CW-1:0]  LAST      = CW'(FRAME_W - 1);
    localparam logic [CW-1:0]  ADDR_LAST = CW'(ADDR_W - 1);
    localparam logic [CW-1:0]  D_FIRST   = CW'(data_first_pos(FRAME_W, DATA_W));
    localparam logic [AW1-1:0] CH_LIM    = AW1'(CHANNELS);

    if (!params_ok(FRAME_W, ADDR_W, DATA_W, CHANNELS)) begin : g_param_check
        $error("spi_reg_rx: illegal FRAME_W/ADDR_W/DATA_W/CHANNELS combination");
    end

    logic [CW-1:0]      bitcnt;
    logic               tc;
    logic               partial;
    logic [FRAME_W-2:0] shreg;
    logic [FRAME_W-1:0] frame_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  regs [CHANNELS];

    logic [ADDR_W-1:0]  c_addr;
    logic               c_we;
    logic [DATA_W-1:0]  c_data;
    logic               c_addr_ok;
    logic [DATA_W-1:0]  sel_word;
    logic [CW-1:0]      didx;
    logic               sdi_nxt;
    logic               unused_frame;

    spi_bitcnt #(
        .FRAME_W (FRAME_W),
        .CW      (CW)
    ) u_bitcnt (
        .sclk    (sclk),
        .reset   (reset),
        .cs_n    (spi.cs_n),
        .bitcnt  (bitcnt),
        .tc      (tc),
        .partial (partial)
    );

    // Frame as it stands once the current sdo bit is shifted in; at the
    // terminal count this is the complete frame, so fields are decoded here.
    always_comb begin
        frame_nxt    = {shreg, spi.sdo};
        c_addr       = frame_nxt[A_MSB -: ADDR_W];
        c_we         = frame_nxt[WE_POS];
        c_data       = frame_nxt[DATA_LSB +: DATA_W];
        c_addr_ok    = ({1'b0, c_addr} < CH_LIM);
        unused_frame = ^frame_nxt;
    end

    // Shift, address capture for readback, commit and sticky error flags.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            addr_q    <= '0;
            ch_toggle <= '0;
            frame_cnt <= '0;
            addr_err  <= 1'b0;
            short_err <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                regs[c] <= '0;
            end
        end else if (!spi.cs_n) begin
            shreg <= frame_nxt[FRAME_W-2:0];
            if (bitcnt == ADDR_LAST) begin
                addr_q <= frame_nxt[ADDR_W-1:0];
            end
            if (bitcnt == '0 && partial) begin
                short_err <= 1'b1;
            end
            if (tc) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
                if (!c_addr_ok) begin
                    addr_err <= 1'b1;
                end else if (c_we) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (c_addr == c[ADDR_W-1:0]) begin
                            regs[c]      <= c_data;
                            ch_toggle[c] <= ~ch_toggle[c];
                        end
                    end
                end
            end
        end
    end

    // Flatten the register bank onto the output bus.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_flat
        assign ch_data[g*DATA_W +: DATA_W] = regs[g];
    end

    // MISO value for position bitcnt: data bits of the addressed register
    // (pre-commit value), zero for address, we, padding and out-of-range.
    always_comb begin
        sel_word = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (addr_q == c[ADDR_W-1:0]) begin
                sel_word = regs[c];
            end
        end
        didx    = LAST - bitcnt;
        sdi_nxt = 1'b0;
        if (bitcnt >= D_FIRST) begin
            sdi_nxt = |(sel_word & (DATA_W'(1) << didx));
        end
    end

    // Mode 0: MISO launches on the falling edge.
    always_ff @(negedge sclk or posedge reset) begin
        if (reset) begin
            spi.sdi <= 1'b0;
        end else begin
            spi.sdi <= sdi_nxt;
        end
    end

endmodule

// File: tb/tb_spi_reg_rx.sv
// tb/tb_spi_reg_rx.sv - directed self-checking bench for spi_reg_rx
module tb_spi_reg_rx;

    logic sclk;
    logic reset;

    spi_reg_rx_if if4 ();
    spi_reg_rx_if if3 ();

    logic [39:0] ch_data4;
    logic [3:0]  ch_toggle4;
    logic [7:0]  frame_cnt4;
    logic        addr_err4;
    logic        short_err4;

    logic [29:0] ch_data3;
    logic [2:0]  ch_toggle3;
    logic [7:0]  frame_cnt3;
    logic        addr_err3;
    logic        short_err3;

    int n_vec;
    int n_err;

    spi_reg_rx #(.CHANNELS(4)) u_dut4 (
        .sclk      (sclk),
        .reset     (reset),
        .spi       (if4),
        .ch_data   (ch_data4),
        .ch_toggle (ch_toggle4),
        .frame_cnt (frame_cnt4),
        .addr_err  (addr_err4),
        .short_err (short_err4)
    );

    spi_reg_rx #(.CHANNELS(3)) u_dut3 (
        .sclk      (sclk),
        .reset     (reset),
        .spi       (if3),
        .ch_data   (ch_data3),
        .ch_toggle (ch_toggle3),
        .frame_cnt (frame_cnt3),
        .addr_err  (addr_err3),
        .short_err (short_err3)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Shift nbits of f MSB first into the selected DUT; got collects the MISO
    // value seen at each serial position (position k lands in got[31-k]).
    task automatic shift_frame(input logic [31:0] f, input int nbits, input bit sel3,
                               input bit hold, output logic [31:0] got);
        got = '0;
        for (int k = 0; k < nbits; k++) begin
            @(negedge sclk);
            #1;
            got[31-k] = sel3 ? if3.sdi : if4.sdi;
            if (sel3) if3.cs_n = 1'b0;
            else      if4.cs_n = 1'b0;
            if3.sdo = f[31-k];
            if4.sdo = f[31-k];
        end
        if (!hold) begin
            @(negedge sclk);
            #1;
            if3.cs_n = 1'b1;
            if4.cs_n = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge sclk);
        #1;
        n_vec++; if (ch_data4 !== 40'h0)  begin n_err++; $display("FAIL rst_ch_data: got %h want 0", ch_data4); end
        n_vec++; if (ch_toggle4 !== 4'h0) begin n_err++; $display("FAIL rst_toggle: got %b want 0", ch_toggle4); end
        n_vec++; if (frame_cnt4 !== 8'h0) begin n_err++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt4); end
        n_vec++; if (addr_err4 !== 1'b0)  begin n_err++; $display("FAIL rst_addr_err: got %b want 0", addr_err4); end
        n_vec++; if (short_err4 !== 1'b0) begin n_err++; $display("FAIL rst_short_err: got %b want 0", short_err4); end
        n_vec++; if (if4.sdi !== 1'b0)    begin n_err++; $display("FAIL rst_sdi: got %b want 0", if4.sdi); end
        reset = 1'b0;
        if3.sdo = 1'b1;
        if4.sdo = 1'b1;
        repeat (32) @(negedge sclk);
        #1;
        n_vec++; if (frame_cnt4 !== 8'h0 || frame_cnt3 !== 8'h0) begin n_err++; $display("FAIL csh_frame_cnt: got %0d/%0d want 0/0", frame_cnt4, frame_cnt3); end
        n_vec++; if (ch_data4 !== 40'h0 || ch_toggle4 !== 4'h0) begin n_err++; $display("FAIL csh_regs: got %h/%b want 0/0", ch_data4, ch_toggle4); end
        n_vec++; if (short_err4 !== 1'b0 || addr_err4 !== 1'b0) begin n_err++; $display("FAIL csh_errs: got %b%b want 00", short_err4, addr_err4); end
    endtask

    task automatic test_write();
        logic [31:0] got;
        shift_frame(32'h6000_0155, 32, 1'b0, 1'b0, got);
        n_vec++; if (ch_data4 !== 40'h00_0005_5400) begin n_err++; $display("FAIL wr_ch_data: got %h want 0000055400", ch_data4); end
        n_vec++; if (ch_toggle4 !== 4'b0010)       begin n_err++; $display("FAIL wr_toggle: got %b want 0010", ch_toggle4); end
        n_vec++; if (frame_cnt4 !== 8'd1)          begin n_err++; $display("FAIL wr_frame_cnt: got %0d want 1", frame_cnt4); end
        n_vec++; if (got !== 32'h0)                begin n_err++; $display("FAIL wr_miso: got %h want 0", got); end
    endtask

    task automatic test_readback();
        logic [31:0] got;
        shift_frame(32'h4000_0000, 32, 1'b0, 1'b0, got);
        n_vec++; if (got !== 32'h0000_0155)        begin n_err++; $display("FAIL rb_miso: got %h want 00000155", got); end
        n_vec++; if (ch_data4 !== 40'h00_0005_5400) begin n_err++; $display("FAIL rb_ch_data: got %h want 0000055400", ch_data4); end
        n_vec++; if (ch_toggle4 !== 4'b0010)       begin n_err++; $display("FAIL rb_toggle: got %b want 0010", ch_toggle4); end
        n_vec++; if (frame_cnt4 !== 8'd2)          begin n_err++; $display("FAIL rb_frame_cnt: got %0d want 2", frame_cnt4); end
    endtask

    task automatic test_truncation();
        logic [31:0] got;
        shift_frame(32'hFFFF_FFFF, 12, 1'b0, 1'b0, got);
        n_vec++; if (frame_cnt4 !== 8'd2 || short_err4 !== 1'b0) begin n_err++; $display("FAIL tr_cut: got cnt %0d short %b want 2/0", frame_cnt4, short_err4); end
        shift_frame(32'h2000_0003, 32, 1'b0, 1'b0, got);
        n_vec++; if (short_err4 !== 1'b1)          begin n_err++; $display("FAIL tr_short_err: got %b want 1", short_err4); end
        n_vec++; if (ch_data4 !== 40'h00_0005_5403) begin n_err++; $display("FAIL tr_ch_data: got %h want 0000055403", ch_data4); end
        n_vec++; if (frame_cnt4 !== 8'd3)          begin n_err++; $display("FAIL tr_frame_cnt: got %0d want 3", frame_cnt4); end
        n_vec++; if (ch_toggle4 !== 4'b0011 || addr_err4 !== 1'b0) begin n_err++; $display("FAIL tr_toggle: got %b/%b want 0011/0", ch_toggle4, addr_err4); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        shift_frame(32'hE000_0011, 32, 1'b1, 1'b1, got);
        shift_frame(32'h6000_0022, 32, 1'b1, 1'b0, got);
        n_vec++; if (addr_err3 !== 1'b1)          begin n_err++; $display("FAIL b2b_addr_err: got %b want 1", addr_err3); end
        n_vec++; if (ch_data3 !== 30'h0000_8800)  begin n_err++; $display("FAIL b2b_ch_data: got %h want 00008800", ch_data3); end
        n_vec++; if (frame_cnt3 !== 8'd2)         begin n_err++; $display("FAIL b2b_frame_cnt: got %0d want 2", frame_cnt3); end
        n_vec++; if (ch_toggle3 !== 3'b010 || short_err3 !== 1'b0) begin n_err++; $display("FAIL b2b_toggle: got %b/%b want 010/0", ch_toggle3, short_err3); end
    endtask

    task automatic test_wrap();
        logic [31:0] got;
        for (int i = 0; i < 254; i++) begin
            shift_frame(32'h0000_0000, 32, 1'b1, (i != 253), got);
        end
        n_vec++; if (frame_cnt3 !== 8'd0) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", frame_cnt3); end
        shift_frame(32'h0000_0000, 32, 1'b1, 1'b0, got);
        n_vec++; if (frame_cnt3 !== 8'd1) begin n_err++; $display("FAIL wrap_one: got %0d want 1", frame_cnt3); end
        n_vec++; if (ch_data3 !== 30'h0000_8800 || short_err3 !== 1'b0) begin n_err++; $display("FAIL wrap_regs: got %h/%b want 00008800/0", ch_data3, short_err3); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] got;
        shift_frame(32'h6000_0155, 17, 1'b0, 1'b1, got);
        @(negedge sclk);
        #1;
        reset = 1'b1;
        @(negedge sclk);
        #1;
        if4.cs_n = 1'b1;
        @(negedge sclk);
        #1;
        reset = 1'b0;
        shift_frame(32'h6000_0155, 32, 1'b0, 1'b0, got);
        n_vec++; if (ch_data4 !== 40'h00_0005_5400) begin n_err++; $display("FAIL rm_ch_data: got %h want 0000055400", ch_data4); end
        n_vec++; if (short_err4 !== 1'b0)          begin n_err++; $display("FAIL rm_short_err: got %b want 0", short_err4); end
        n_vec++; if (frame_cnt4 !== 8'd1 || ch_toggle4 !== 4'b0010) begin n_err++; $display("FAIL rm_cnt: got %0d/%b want 1/0010", frame_cnt4, ch_toggle4); end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        if4.cs_n = 1'b1;
        if3.cs_n = 1'b1;
        if4.sdo  = 1'b0;
        if3.sdo  = 1'b0;
        test_reset();
        test_write();
        test_readback();
        test_truncation();
        test_back_to_back();
        test_wrap();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
